gigatron_video_capture: RTL

GIGATRON_VIDEO_CAPTURE -- requirements
Module: gigatron_video_capture

---
 rtl/gigatron_video_capture.sv | 127 ++++++++++++
 1 files changed

// File: rtl/gigatron_video_capture.sv
// Gigatron video capture: turns the sampled OUT register (sync bits plus
// BBGGRR colour) into a stream of visible pixels with x/y coordinates,
// line/frame strobes, a frame counter and a lock flag.
module gigatron_video_capture #(
  parameter int H_BP     = 12,
  parameter int H_ACTIVE = 160,
  parameter int V_BP     = 29,
  parameter int V_ACTIVE = 480
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_ready,
  input  logic [7:0]  i_out,
  output logic        o_pix_valid,
  output logic [7:0]  o_pix_x,
  output logic [8:0]  o_pix_y,
  output logic [5:0]  o_pix_rgb,
  output logic        o_line_start,
  output logic        o_frame_start,
  output logic [15:0] o_frame_count,
  output logic        o_locked
);

  // Visible window bounds, widened so the comparisons stay exact.
  localparam logic [31:0] H_LO = 32'(H_BP);
  localparam logic [31:0] H_HI = 32'(H_BP + H_ACTIVE);
  localparam logic [31:0] V_LO = 32'(V_BP);
  localparam logic [31:0] V_HI = 32'(V_BP + V_ACTIVE);

  localparam logic [8:0] HCNT_MAX = 9'd511;
  localparam logic [9:0] VCNT_MAX = 10'd1023;

  logic        prev_h_reg;
  logic        prev_v_reg;
  logic [8:0]  hcnt_reg;
  logic [8:0]  hcnt_next;
  logic [9:0]  vcnt_reg;
  logic [9:0]  vcnt_next;
  logic        pix_valid_reg;
  logic [7:0]  pix_x_reg;
  logic [8:0]  pix_y_reg;
  logic [5:0]  pix_rgb_reg;
  logic        line_start_reg;
  logic        frame_start_reg;
  logic [15:0] frame_count_reg;
  logic        locked_reg;

  logic        h_rise;
  logic        v_rise;
  logic        h_in_window;
  logic        v_in_window;
  logic        visible;

  // Edge detection and next-state of the beam position counters.
  always_comb begin
    h_rise      = i_ready && !prev_h_reg && i_out[7];
    v_rise      = i_ready && !prev_v_reg && i_out[6];
    h_in_window = ({23'd0, hcnt_reg} >= H_LO) && ({23'd0, hcnt_reg} < H_HI);
    v_in_window = ({22'd0, vcnt_reg} >= V_LO) && ({22'd0, vcnt_reg} < V_HI);
    // Position is judged on the counters as they stood before this sample.
    visible     = i_ready && locked_reg && h_in_window && v_in_window;

    hcnt_next = hcnt_reg;
    if (i_ready) begin
      if (h_rise) begin
        hcnt_next = 9'd0;
      end else if (hcnt_reg != HCNT_MAX) begin
        hcnt_next = hcnt_reg + 9'd1;
      end
    end

    // A vsync edge wins over a coincident hsync edge: the line count restarts at 0.
    vcnt_next = vcnt_reg;
    if (v_rise) begin
      vcnt_next = 10'd0;
    end else if (h_rise && (vcnt_reg != VCNT_MAX)) begin
      vcnt_next = vcnt_reg + 10'd1;
    end
  end

  // State and output registers; strobes fall back to 0 on every non-event edge.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      prev_h_reg      <= 1'b1;
      prev_v_reg      <= 1'b1;
      hcnt_reg        <= HCNT_MAX;
      vcnt_reg        <= VCNT_MAX;
      pix_valid_reg   <= 1'b0;
      pix_x_reg       <= 8'd0;
      pix_y_reg       <= 9'd0;
      pix_rgb_reg     <= 6'd0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_count_reg <= 16'd0;
      locked_reg      <= 1'b0;
    end else begin
      if (i_ready) begin
        prev_h_reg <= i_out[7];
        prev_v_reg <= i_out[6];
      end
      hcnt_reg        <= hcnt_next;
      vcnt_reg        <= vcnt_next;
      pix_valid_reg   <= visible;
      line_start_reg  <= h_rise;
      frame_start_reg <= v_rise;
      if (visible) begin
        pix_x_reg   <= 8'(hcnt_reg - H_LO[8:0]);
        pix_y_reg   <= 9'(vcnt_reg - V_LO[9:0]);
        pix_rgb_reg <= i_out[5:0];
      end
      if (v_rise) begin
        frame_count_reg <= frame_count_reg + 16'd1;
        locked_reg      <= 1'b1;
      end
    end
  end

  assign o_pix_valid   = pix_valid_reg;
  assign o_pix_x       = pix_x_reg;
  assign o_pix_y       = pix_y_reg;
  assign o_pix_rgb     = pix_rgb_reg;
  assign o_line_start  = line_start_reg;
  assign o_frame_start = frame_start_reg;
  assign o_frame_count = frame_count_reg;
  assign o_locked      = locked_reg;

endmodule
